// File: rtl/user_proj_mprjram_pkg.sv
// Shared constants for the mprjram user project: bus address map and default memory latency.
package user_proj_mprjram_pkg;

  localparam logic [31:0] RAM_BASE      = 32'h3800_0000;
  localparam logic [31:0] REG_BASE      = 32'h3000_0000;
  localparam int          DEFAULT_DELAY = 10;
  localparam logic [7:0]  RAM_REGION    = 8'h38;
  localparam logic [7:0]  REG_REGION    = 8'h30;

  // Byte-lane merge used by the status register write.
  function automatic logic [15:0] merge16(input logic [15:0] old_v, input logic [15:0] new_v,
                                          input logic [1:0] sel);
    merge16 = old_v;
    if (sel[0]) merge16[7:0]  = new_v[7:0];
    if (sel[1]) merge16[15:8] = new_v[15:8];
  endfunction

endpackage

// File: rtl/user_proj_mprjram_bram.sv
// Single-port DEPTH x 32 synchronous RAM with byte write enables and a registered read.
module user_proj_mprjram_bram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Read-first: rdata returns the word as it was before any write in the same cycle.
  always_ff @(posedge clock) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/user_proj_mprjram.sv
// Wishbone slave: delayed-ack execution memory at 0x38xxxxxx and a 16-bit status register
// at 0x30000000 that drives mprj_io[31:16] and the logic analyzer.
module user_proj_mprjram
  import user_proj_mprjram_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int DELAY = DEFAULT_DELAY
) (
  input  logic         clock,
  input  logic         resetb,
  input  logic         wbs_cyc_i,
  input  logic         wbs_stb_i,
  input  logic         wbs_we_i,
  input  logic [3:0]   wbs_sel_i,
  input  logic [31:0]  wbs_adr_i,
  input  logic [31:0]  wbs_dat_i,
  output logic         wbs_ack_o,
  output logic [31:0]  wbs_dat_o,
  input  logic [127:0] la_data_in,
  input  logic [127:0] la_oenb,
  output logic [127:0] la_data_out,
  input  logic [37:0]  io_in,
  output logic [37:0]  io_out,
  output logic [37:0]  io_oeb,
  output logic [2:0]   irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DELAY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DELAY);

  logic          req, ram_sel, reg_sel, reg_hit;
  logic          ram_fire, reg_fire;
  logic [CW-1:0] cnt;
  logic          ack_q, ack_ram_q;
  logic [15:0]   status;
  logic [31:0]   reg_rdata_q;
  logic [31:0]   ram_rdata;
  logic          unused_inputs;

  assign req     = wbs_cyc_i & wbs_stb_i;
  assign ram_sel = req & (wbs_adr_i[31:24] == RAM_REGION);
  assign reg_sel = req & (wbs_adr_i[31:24] == REG_REGION);
  assign reg_hit = (wbs_adr_i == REG_BASE);

  // Requests are only considered while no ack is showing, which forces a gap cycle after every ack.
  assign ram_fire = ram_sel & ~ack_q & (cnt == CNT_LAST);
  assign reg_fire = reg_sel & ~ack_q;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cnt         <= '0;
      ack_q       <= 1'b0;
      ack_ram_q   <= 1'b0;
      status      <= '0;
      reg_rdata_q <= '0;
    end else begin
      ack_q     <= ram_fire | reg_fire;
      ack_ram_q <= ram_fire;
      // Dropping the request (or leaving the region) restarts the wait from zero.
      if (ram_sel && !ack_q && !ram_fire) cnt <= cnt + 1'b1;
      else                                 cnt <= '0;
      if (reg_fire) begin
        reg_rdata_q <= reg_hit ? {16'h0000, status} : 32'h0;
        if (wbs_we_i && reg_hit) status <= merge16(status, wbs_dat_i[15:0], wbs_sel_i[1:0]);
      end
    end
  end

  // The RAM is touched exactly once per access, on the edge that raises ack.
  user_proj_mprjram_bram #(.DEPTH(DEPTH)) u_bram (
    .clock (clock),
    .en    (ram_fire),
    .we    (wbs_we_i ? wbs_sel_i : 4'b0000),
    .addr  (wbs_adr_i[AW+1:2]),
    .wdata (wbs_dat_i),
    .rdata (ram_rdata)
  );

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = !ack_q ? 32'h0 : (ack_ram_q ? ram_rdata : reg_rdata_q);
  assign la_data_out = {112'h0, status};
  assign io_out      = {6'h00, status, 16'h0000};
  assign io_oeb      = {6'h3f, 16'h0000, 16'hffff};
  assign irq         = 3'b000;

  assign unused_inputs = ^{la_data_in, la_oenb, io_in, wbs_adr_i[23:AW+2], wbs_adr_i[1:0]};

endmodule

// File: tb/tb_user_proj_mprjram.sv
// Randomized self-checking bench for user_proj_mprjram against a word-array/status reference model.
module tb_user_proj_mprjram;

  localparam int DEPTH = 1024;
  localparam int DELAY = 10;
  localparam int NOACK = -1;

  logic         clock = 1'b0;
  logic         resetb = 1'b0;
  logic         wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]   wbs_sel_i = 4'h0;
  logic [31:0]  wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
  logic         wbs_ack_o;
  logic [31:0]  wbs_dat_o;
  logic [127:0] la_data_in = '0, la_oenb = '1, la_data_out;
  logic [37:0]  io_in = '0, io_out, io_oeb;
  logic [2:0]   irq;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: word-addressed memory with wrap-around, plus the status register.
  logic [31:0] ref_mem [DEPTH];
  logic [15:0] ref_status = 16'h0;

  user_proj_mprjram #(.DEPTH(DEPTH), .DELAY(DELAY)) dut (
    .clock(clock), .resetb(resetb),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .la_data_in(la_data_in), .la_oenb(la_oenb), .la_data_out(la_data_out),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] adr);
    return int'((adr >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] sel);
    logic [31:0] r = old_v;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  // One Wishbone access. Inputs change 1 time unit after a rising edge; outputs are
  // sampled there too. lat = number of edges from request to ack, or NOACK.
  task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                         input logic [31:0] wdat, input int budget, input bit hold,
                         output logic [31:0] rdat, output int lat);
    lat = NOACK;
    rdat = 32'h0;
    @(posedge clock); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel; wbs_adr_i = adr; wbs_dat_i = wdat;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clock); #1;
      if (wbs_ack_o) begin
        lat = i;
        rdat = wbs_dat_o;
        break;
      end
    end
    if (hold && lat != NOACK) begin
      @(posedge clock); #1;
      check("ack_gap", {31'h0, wbs_ack_o}, 32'h0);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
  endtask

  task automatic ram_write(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] d);
    logic [31:0] r;
    int lat;
    wb_xfer(adr, 1'b1, sel, d, 3 * DELAY, 1'b0, r, lat);
    check("ram_wr_lat", lat, DELAY + 1);
    ref_mem[widx(adr)] = merge(ref_mem[widx(adr)], d, sel);
  endtask

  task automatic ram_read(input string tag, input logic [31:0] adr, input bit hold);
    logic [31:0] r;
    int lat;
    wb_xfer(adr, 1'b0, 4'hf, 32'h0, 3 * DELAY, hold, r, lat);
    check({tag, "_lat"}, lat, DELAY + 1);
    check(tag, r, ref_mem[widx(adr)]);
  endtask

  task automatic reg_write(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] d);
    logic [31:0] r;
    int lat;
    wb_xfer(adr, 1'b1, sel, d, 3 * DELAY, 1'b0, r, lat);
    check("reg_wr_lat", lat, 1);
    if (adr == 32'h3000_0000) begin
      if (sel[0]) ref_status[7:0]  = d[7:0];
      if (sel[1]) ref_status[15:8] = d[15:8];
    end
  endtask

  task automatic reg_read(input logic [31:0] adr);
    logic [31:0] r;
    int lat;
    wb_xfer(adr, 1'b0, 4'hf, 32'h0, 3 * DELAY, 1'b0, r, lat);
    check("reg_rd_lat", lat, 1);
    check("reg_rd", r, (adr == 32'h3000_0000) ? {16'h0, ref_status} : 32'h0);
  endtask

  task automatic check_pins(input string tag);
    check({tag, "_io"}, {16'h0, io_out[31:16]}, {16'h0, ref_status});
    check({tag, "_la"}, la_data_out[31:0], {16'h0, ref_status});
  endtask

  initial begin
    logic [31:0] r;
    int lat;
    logic [31:0] pool [16];

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
    check("rst_dat", wbs_dat_o, 32'h0);
    check("rst_la_hi", la_data_out[127:96], 32'h0);
    check_pins("rst");
    resetb = 1'b1;
    check("oeb_lo", {26'h0, io_oeb[5:0]}, 32'h3f);
    check("oeb_mid", {6'h0, io_oeb[37:32], io_oeb[31:16], 4'h0}, {6'h0, 6'h3f, 16'h0, 4'h0});
    check("oeb_low16", {16'h0, io_oeb[15:0]}, 32'h0000ffff);
    check("irq", {29'h0, irq}, 32'h0);

    // Status register and directed RAM traffic.
    reg_write(32'h3000_0000, 4'b0011, 32'h1234_AB40);
    check_pins("st1");
    ram_write(32'h3800_0000, 4'hf, 32'h0000_003E);
    ram_read("ram0", 32'h3800_0000, 1'b1);
    ram_write(32'h3800_0004, 4'hf, 32'h44);
    ram_write(32'h3800_0008, 4'hf, 32'h4A);
    ram_write(32'h3800_000C, 4'hf, 32'h50);
    for (int i = 0; i < 4; i++) ram_read("seq", 32'h3800_0000 + 32'(4 * i), 1'b0);
    reg_write(32'h3000_0000, 4'b1111, 32'hFFFF_AB50);
    check_pins("st2");
    reg_read(32'h3000_0000);

    // Byte enables and address aliasing.
    ram_write(32'h3800_0010, 4'hf, 32'hFFFF_FFFF);
    ram_write(32'h3800_0010, 4'b0001, 32'h0000_0012);
    check("byte_model", ref_mem[4], 32'hFFFF_FF12);
    ram_read("byte", 32'h3800_0010, 1'b0);
    ram_read("alias", 32'h3800_0010 + 32'(4 * DEPTH), 1'b0);

    // Abort after 3 cycles: no ack, no write.
    wb_xfer(32'h3800_0010, 1'b1, 4'hf, 32'hDEAD_BEEF, 3, 1'b0, r, lat);
    check("abort_noack", lat, NOACK);
    repeat (DELAY + 2) begin
      @(posedge clock); #1;
      check("abort_quiet", {31'h0, wbs_ack_o}, 32'h0);
    end
    ram_read("abort_rd", 32'h3800_0010, 1'b0);

    // Unmapped region and unmapped status-space address.
    wb_xfer(32'h2000_0000, 1'b0, 4'hf, 32'h0, 2 * DELAY, 1'b0, r, lat);
    check("unmapped", lat, NOACK);
    reg_read(32'h3000_0004);
    reg_write(32'h3000_0004, 4'hf, 32'h0000_5555);
    check_pins("st3");

    // Randomized mix over a small pool of words plus status writes.
    for (int i = 0; i < 16; i++) begin
      pool[i] = 32'h3800_0000 + 32'($urandom_range(0, 4 * DEPTH - 1) * 4);
      ram_write(pool[i], 4'hf, $urandom);
    end
    for (int n = 0; n < 60; n++) begin
      int k = $urandom_range(0, 15);
      case ($urandom_range(0, 3))
        0: ram_write(pool[k], 4'($urandom_range(0, 15)), $urandom);
        1: ram_read("rnd_rd", pool[k], 1'($urandom_range(0, 1)));
        2: begin
          reg_write(32'h3000_0000, 4'($urandom_range(0, 15)), $urandom);
          check_pins("rnd_st");
        end
        default: ram_read("rnd_rd2", pool[k], 1'b0);
      endcase
    end

    // Reset in the middle of a pending RAM write: no ack, no write, status cleared.
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hf;
    wbs_adr_i = pool[0]; wbs_dat_i = ~ref_mem[widx(pool[0])];
    repeat (5) @(posedge clock);
    #3;
    resetb = 1'b0;
    #1;
    check("rst_mid_ack", {31'h0, wbs_ack_o}, 32'h0);
    ref_status = 16'h0;
    check_pins("rst_mid");
    for (int i = 0; i < DELAY + 2; i++) begin
      @(posedge clock); #1;
      check("rst_hold_ack", {31'h0, wbs_ack_o}, 32'h0);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(posedge clock); #1;
    resetb = 1'b1;
    ram_read("after_rst", pool[0], 1'b0);
    check_pins("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/user_proj_mprjram.md
Name: user_proj_mprjram

Overview:
- User-project block on the Caravel Wishbone bus.
- Provides the execution/data memory "mprjram" at 0x3800_0000. Firmware (e.g. matmul) is copied there and run from it.
- Memory accesses are acknowledged after a fixed SDRAM-like delay.
- Also provides a 16-bit status register at 0x3000_0000 that drives mprj_io[31:16] (checkbits) and is mirrored on the logic analyzer.

Parameters:
- DEPTH, 1024, memory size in 32-bit words (power of 2).
- DELAY, 10, wait cycles from request accept to ack for mprjram accesses (≥1).
- RAM_BASE, 32'h3800_0000, mprjram region; decoded on adr[31:24].
- REG_BASE, 32'h3000_0000, status register address (full 32-bit match).

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- resetb  in  1  asynchronous, active-low reset.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data, valid only while ack=1.
- la_data_in  in  128  LA inputs; unused.
- la_oenb  in  128  LA enables; unused.
- la_data_out  out  128  {112'b0, status[15:0]}.
- io_in  in  38  unused.
- io_out  out  38  [31:16] = status[15:0]; all other bits 0.
- io_oeb  out  38  [31:16] = 0 (driven); all other bits 1.
- irq  out  3  tied 0.

Behaviour:
- Request: req = cyc & stb.
  - ram_sel = req & (adr[31:24] == 8'h38).
  - reg_sel = req & (adr[31:24] == 8'h30).
  - Any other address: no ack, no state change.
- mprjram path, wait counter cnt:
  - While ram_sel and no ack is pending, cnt increments each cycle.
  - When cnt reaches DELAY, ack is asserted in the next cycle (one cycle only) and cnt returns to 0.
  - Ack therefore occurs DELAY+1 cycles after the first cycle req was seen.
- mprjram read: word index = adr[log2(DEPTH)+1:2], so upper bits alias (wrap-around). wbs_dat_o = mem[index], presented in the ack cycle.
- mprjram write: happens in the ack cycle. Only bytes with sel[i]=1 are updated. Write data is sampled at the ack edge.
- Status register path (reg_sel):
  - Ack one cycle after the request.
  - adr == REG_BASE: write updates status[15:0] per sel[1:0], and sel[3:2] are ignored. Read returns {16'b0, status}.
  - Other 0x30xxxxxx addresses: ack, read 0, write ignored.
- Ack shape: ack is low on the cycle after any ack, even if stb stays high. The next request starts counting from that cycle.
- Abort: if cyc or stb drops before ack, cnt clears to 0 and no write occurs.
- Reset (async assert, sync deassert in the integration context) forces:
  - wbs_ack_o = 0, wbs_dat_o = 0, cnt = 0, status = 0;
  - io_out[31:16] = 0 and la_data_out = 0.
  - Memory contents are not reset.
  - Reset during a pending access cancels it with no write.
- wbs_dat_o is 0 whenever ack = 0.

Decomposition:
- Shared package: RAM_BASE, REG_BASE, the default DELAY value, and the region-decode constants 8'h38 and 8'h30.
- One sub-module, mprjram_bram: single-port DEPTH×32 synchronous RAM with 4 byte-write enables and 1-cycle read. The read is issued in the cycle before ack so its data appears in the ack cycle.

Test Plan:
- Reset, then read io_out[31:16] → 0x0000. Write 0xAB40 to 0x3000_0000 with sel = 4'b0011 → io_out[31:16] = 0xAB40 and la_data_out[15:0] = 0xAB40, ack exactly 1 cycle after stb.
- Write 0x0000003E to 0x3800_0000, then read it back → ack DELAY+1 cycles after stb each time; data = 0x0000003E.
- Store 0x3E, 0x44, 0x4A, 0x50 at 0x3800_0000–0x3800_000C and read them back in sequence → exact values; status written 0xAB50 afterwards → io_out[31:16] = 0xAB50.
- Write 0xFFFFFFFF to 0x3800_0010, then write 0x00000012 with sel = 4'b0001 → readback 0xFFFFFF12. Read 0x3800_0010 + 4·DEPTH → same word (alias).
- Write with stb dropped after 3 cycles, then read → old data unchanged, no ack. Assert resetb low mid-access → ack never asserted and status = 0.
- Access 0x2000_0000 → no ack within 2·DELAY cycles. Read 0x3000_0004 → ack, data 0.
